// File: rtl/usb_hub_upstream_arbiter.sv
// Round-robin arbiter granting the hub's upstream transmit path to one downstream port per packet.
// Optional packet-length watchdog is compiled in with `define USB_HUB_ARB_TIMEOUT_EN.
module usb_hub_upstream_arbiter #(
  parameter int NUM_USB_DEVICES = 2,
  parameter int IPG_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int W = (NUM_USB_DEVICES > 1) ? $clog2(NUM_USB_DEVICES) : 1
) (
  input  logic                       hi_clock,
  input  logic                       reset_n,
  input  logic [NUM_USB_DEVICES-1:0] dev_req,
  input  logic [NUM_USB_DEVICES-1:0] dev_eop,
  input  logic [NUM_USB_DEVICES-1:0] port_enable,
  input  logic                       host_tx_ready,
  output logic [NUM_USB_DEVICES-1:0] dev_grant,
  output logic [W-1:0]               grant_idx,
  output logic                       host_tx_busy,
  output logic                       timeout_err,
  output logic [1:0]                 state_dbg
);

  if (NUM_USB_DEVICES < 2 || NUM_USB_DEVICES > 16 || IPG_CYCLES < 1 || IPG_CYCLES > 255 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("usb_hub_upstream_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t                     state;
  logic [W-1:0]               last;
  logic [7:0]                 gap_cnt;
  logic [NUM_USB_DEVICES-1:0] eligible;
  logic                       any_eligible;
  logic [W-1:0]               pick;
  logic [NUM_USB_DEVICES-1:0] pick_onehot;
  logic                       found;
  logic                       eop_hit;
  logic                       en_lost;

  // Handshake: a port requests by holding dev_req (qualified by port_enable); the
  // transfer starts when host_tx_ready is seen in IDLE and ends on that port's dev_eop.
  assign eligible     = dev_req & port_enable;
  assign any_eligible = |eligible;
  assign eop_hit      = |(dev_eop & dev_grant);
  assign en_lost      = ~|(port_enable & dev_grant);
  assign state_dbg    = state;

  // Search upward from last+1, wrapping, so the most recent winner has lowest priority.
  always_comb begin
    int idx;
    pick        = '0;
    pick_onehot = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 1; k <= NUM_USB_DEVICES; k++) begin
      idx = (int'(last) + k) % NUM_USB_DEVICES;
      if (!found && eligible[idx]) begin
        found            = 1'b1;
        pick             = idx[W-1:0];
        pick_onehot[idx] = 1'b1;
      end
    end
  end

`ifdef USB_HUB_ARB_TIMEOUT_EN
  logic [15:0] wdt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge hi_clock) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      dev_grant    <= '0;
      grant_idx    <= '0;
      host_tx_busy <= 1'b0;
      last         <= W'(NUM_USB_DEVICES - 1);
      gap_cnt      <= '0;
`ifdef USB_HUB_ARB_TIMEOUT_EN
      wdt          <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
`ifdef USB_HUB_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (host_tx_ready && any_eligible) begin
            dev_grant    <= pick_onehot;
            grant_idx    <= pick;
            last         <= pick;
            host_tx_busy <= 1'b1;
            state        <= S_GRANT;
`ifdef USB_HUB_ARB_TIMEOUT_EN
            wdt          <= '0;
`endif
          end
        end
        S_GRANT: begin
          // eop outranks both disable and watchdog expiry in the same cycle
          if (eop_hit || en_lost) begin
            dev_grant    <= '0;
            host_tx_busy <= 1'b0;
            gap_cnt      <= '0;
            state        <= S_GAP;
          end
`ifdef USB_HUB_ARB_TIMEOUT_EN
          else if (wdt == 16'(TIMEOUT_CYCLES - 1)) begin
            dev_grant    <= '0;
            host_tx_busy <= 1'b0;
            gap_cnt      <= '0;
            timeout_err  <= 1'b1;
            state        <= S_GAP;
          end else begin
            wdt <= wdt + 16'd1;
          end
`endif
        end
        S_GAP: begin
          if (gap_cnt == 8'(IPG_CYCLES - 1)) begin
            gap_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_hub_upstream_arbiter.sv
// Directed bench for usb_hub_upstream_arbiter (N=4, IPG=4, TIMEOUT=8).
// Watchdog expectations follow USB_HUB_ARB_TIMEOUT_EN as seen at compile time.
module tb_usb_hub_upstream_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic         hi_clock = 1'b0;
  logic         reset_n;
  logic [N-1:0] dev_req;
  logic [N-1:0] dev_eop;
  logic [N-1:0] port_enable;
  logic         host_tx_ready;
  logic [N-1:0] dev_grant;
  logic [W-1:0] grant_idx;
  logic         host_tx_busy;
  logic         timeout_err;
  logic [1:0]   state_dbg;

  int errors = 0;
  int checks = 0;

  usb_hub_upstream_arbiter #(
    .NUM_USB_DEVICES(N),
    .IPG_CYCLES(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .hi_clock(hi_clock),
    .reset_n(reset_n),
    .dev_req(dev_req),
    .dev_eop(dev_eop),
    .port_enable(port_enable),
    .host_tx_ready(host_tx_ready),
    .dev_grant(dev_grant),
    .grant_idx(grant_idx),
    .host_tx_busy(host_tx_busy),
    .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 hi_clock = ~hi_clock;

  task automatic step(input int n);
    repeat (n) @(posedge hi_clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    dev_req       = '0;
    dev_eop       = '0;
    port_enable   = '1;
    host_tx_ready = 1'b1;
    step(2);
    reset_n = 1'b1;
  endtask

  // drivers
  task automatic pulse_eop(input logic [N-1:0] m);
    dev_eop = m;
    step(1);
    dev_eop = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (state_dbg != 2'd0 && n < 20) begin
      step(1);
      n++;
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL wait_idle: state=%0d after %0d cycles, required 0", state_dbg, n);
    end
  endtask

  task automatic count_to_grant(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (dev_grant == '0 && n < 20);
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    dev_req       = 4'b1111;
    dev_eop       = '0;
    port_enable   = '1;
    host_tx_ready = 1'b1;
    step(2);
    checks++; if (dev_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b required 0000", dev_grant); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d required 0", grant_idx); end
    checks++; if (host_tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", host_tx_busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b required 0", timeout_err); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
    dev_req = '0;
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_single_request();
    dev_req = 4'b0001;
    step(1);
    checks++; if (dev_grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b required 0001", dev_grant); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL single_idx: got %0d required 0", grant_idx); end
    checks++; if (host_tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b required 1", host_tx_busy); end
    pulse_eop(4'b0001);
    checks++; if (dev_grant !== 4'b0000) begin errors++; $display("FAIL single_release: got %b required 0000", dev_grant); end
    checks++; if (host_tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_off: got %b required 0", host_tx_busy); end
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL single_gap_state: got %0d required 2", state_dbg); end
    step(4);
    checks++; if (dev_grant !== 4'b0000) begin errors++; $display("FAIL single_gap_block: got %b required 0000", dev_grant); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL single_idle_after_gap: got %0d required 0", state_dbg); end
    step(1);
    checks++; if (dev_grant !== 4'b0001) begin errors++; $display("FAIL single_regrant: got %b required 0001", dev_grant); end
    pulse_eop(4'b0001);
    dev_req = '0;
    wait_idle();
  endtask

  task automatic test_fairness();
    int n;
    int e;
    logic [N-1:0] g;
    logic [N-1:0] expg;
    do_reset();
    dev_req = 4'b1111;
    step(1);
    checks++; if (dev_grant !== 4'b0001) begin errors++; $display("FAIL fair_first: got %b required 0001", dev_grant); end
    for (int i = 1; i <= 4; i++) begin
      e    = i % 4;
      expg = 4'b0001 << e;
      g    = dev_grant;
      step(2);
      pulse_eop(g);
      count_to_grant(n);
      checks++; if (n !== 5) begin errors++; $display("FAIL fair_spacing_%0d: got %0d edges required 5", i, n); end
      checks++; if (dev_grant !== expg) begin errors++; $display("FAIL fair_grant_%0d: got %b required %b", i, dev_grant, expg); end
      checks++; if (grant_idx !== W'(e)) begin errors++; $display("FAIL fair_idx_%0d: got %0d required %0d", i, grant_idx, e); end
    end
    pulse_eop(dev_grant);
    dev_req = '0;
    wait_idle();
  endtask

  task automatic test_watchdog();
    do_reset();
    dev_req = 4'b0010;
    step(1);
    checks++; if (dev_grant !== 4'b0010) begin errors++; $display("FAIL wdt_grant: got %b required 0010", dev_grant); end
    checks++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL wdt_idx: got %0d required 1", grant_idx); end
`ifdef USB_HUB_ARB_TIMEOUT_EN
    step(7);
    checks++; if (dev_grant !== 4'b0010) begin errors++; $display("FAIL wdt_hold: got %b required 0010", dev_grant); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wdt_early: got %b required 0", timeout_err); end
    step(1);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wdt_fire: got %b required 1", timeout_err); end
    checks++; if (dev_grant !== 4'b0000) begin errors++; $display("FAIL wdt_drop: got %b required 0000", dev_grant); end
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL wdt_gap: got %0d required 2", state_dbg); end
    step(1);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wdt_pulse_width: got %b required 0", timeout_err); end
    dev_req = '0;
`else
    step(8);
    checks++; if (dev_grant !== 4'b0010) begin errors++; $display("FAIL nowdt_hold: got %b required 0010", dev_grant); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL nowdt_err: got %b required 0", timeout_err); end
    pulse_eop(4'b0010);
    dev_req = '0;
`endif
    wait_idle();
  endtask

  task automatic test_disable();
    int n;
    do_reset();
    dev_req = 4'b0011;
    step(1);
    checks++; if (dev_grant !== 4'b0001) begin errors++; $display("FAIL dis_grant: got %b required 0001", dev_grant); end
    port_enable = 4'b1110;
    step(1);
    checks++; if (dev_grant !== 4'b0000) begin errors++; $display("FAIL dis_drop: got %b required 0000", dev_grant); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL dis_no_timeout: got %b required 0", timeout_err); end
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL dis_gap: got %0d required 2", state_dbg); end
    count_to_grant(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL dis_spacing: got %0d edges required 5", n); end
    checks++; if (dev_grant !== 4'b0010) begin errors++; $display("FAIL dis_next: got %b required 0010", dev_grant); end
    step(2);
    pulse_eop(4'b0010);
    count_to_grant(n);
    checks++; if (dev_grant !== 4'b0010) begin errors++; $display("FAIL dis_skip_port0: got %b required 0010", dev_grant); end
    pulse_eop(4'b0010);
    port_enable = '1;
    dev_req     = '0;
    wait_idle();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    dev_req = 4'b0010;
    step(1);
    checks++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL midrst_pre_idx: got %0d required 1", grant_idx); end
    dev_req = 4'b0011;
    reset_n = 1'b0;
    step(1);
    checks++; if (dev_grant !== 4'b0000) begin errors++; $display("FAIL midrst_grant: got %b required 0000", dev_grant); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL midrst_idx: got %0d required 0", grant_idx); end
    checks++; if (host_tx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", host_tx_busy); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d required 0", state_dbg); end
    reset_n = 1'b1;
    step(1);
    checks++; if (dev_grant !== 4'b0001) begin errors++; $display("FAIL midrst_regrant: got %b required 0001", dev_grant); end
    pulse_eop(4'b0001);
    dev_req = '0;
    wait_idle();
  endtask

  task automatic test_stray_eop_not_ready();
    do_reset();
    dev_req = 4'b0001;
    step(1);
    pulse_eop(4'b0010);
    checks++; if (dev_grant !== 4'b0001) begin errors++; $display("FAIL stray_eop_grant: got %b required 0001", dev_grant); end
    checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL stray_eop_state: got %0d required 1", state_dbg); end
    host_tx_ready = 1'b0;
    step(1);
    checks++; if (dev_grant !== 4'b0001) begin errors++; $display("FAIL ready_drop_grant: got %b required 0001", dev_grant); end
    pulse_eop(4'b0001);
    dev_req = '0;
    wait_idle();
    dev_req = 4'b0011;
    step(3);
    checks++; if (dev_grant !== 4'b0000) begin errors++; $display("FAIL not_ready_block: got %b required 0000", dev_grant); end
    host_tx_ready = 1'b1;
    step(1);
    checks++; if (dev_grant !== 4'b0010) begin errors++; $display("FAIL ready_rise_grant: got %b required 0010", dev_grant); end
    checks++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL ready_rise_idx: got %0d required 1", grant_idx); end
    pulse_eop(4'b0010);
    dev_req = '0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_fairness();
    test_watchdog();
    test_disable();
    test_reset_mid_grant();
    test_stray_eop_not_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
